// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/acknowledge bus between the fetch sequencer and imem.
interface fetch_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: one outstanding imem request, one-entry output slot to decode,
// redirect handling that discards an in-flight wrong-path response.
module fetch_ctrl #(
    parameter logic [31:0] PC_INIT = 32'hBFC0_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    fetch_ctrl_if.master       imem,
    output logic               if_valid,
    output logic [31:0]        if_pc,
    output logic [31:0]        if_instr,
    output logic [31:0]        if_npc
);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_WAIT = 2'd1,
        S_KILL = 2'd2
    } state_t;

    state_t      state_r, state_n;
    logic [31:0] pc_r, pc_n;
    logic [31:0] tgt_r, tgt_n;
    logic        if_valid_r, if_valid_n;
    logic [31:0] if_pc_r, if_pc_n;
    logic [31:0] if_instr_r, if_instr_n;

    logic        consume_s;
    logic        free_next_s;
    logic        req_s;
    logic        ack_s;
    logic [31:0] target_s;

    assign consume_s   = if_valid_r & ~stall;
    assign free_next_s = ~if_valid_r | consume_s;
    assign target_s    = redirect_pc & 32'hFFFF_FFFC;
    // imem_ack is meaningless without an outstanding request
    assign ack_s       = req_s & imem.imem_ack;

    // Mealy request: a new fetch in S_RUN only when the slot will be free; held while outstanding
    always_comb begin
        req_s = 1'b0;
        if (rst) begin
            req_s = 1'b0;
        end else begin
            case (state_r)
                S_RUN:   req_s = free_next_s & ~redirect;
                S_WAIT:  req_s = 1'b1;
                S_KILL:  req_s = 1'b1;
                default: req_s = 1'b0;
            endcase
        end
    end

    // Next-state, pc, redirect target and output-slot update
    always_comb begin
        state_n    = state_r;
        pc_n       = pc_r;
        tgt_n      = tgt_r;
        if_valid_n = if_valid_r;
        if_pc_n    = if_pc_r;
        if_instr_n = if_instr_r;
        case (state_r)
            S_RUN: begin
                if (redirect) begin
                    pc_n       = target_s;
                    if_valid_n = 1'b0;
                end else if (ack_s) begin
                    if_pc_n    = pc_r;
                    if_instr_n = imem.imem_rdata;
                    if_valid_n = 1'b1;
                    pc_n       = pc_r + 32'd4;
                end else if (req_s) begin
                    // request implies the slot was empty or is being consumed now
                    state_n    = S_WAIT;
                    if_valid_n = 1'b0;
                end else begin
                    if_valid_n = if_valid_r;
                end
            end
            S_WAIT: begin
                if_valid_n = 1'b0;
                if (ack_s) begin
                    state_n = S_RUN;
                    if (redirect) begin
                        pc_n = target_s;
                    end else begin
                        if_pc_n    = pc_r;
                        if_instr_n = imem.imem_rdata;
                        if_valid_n = 1'b1;
                        pc_n       = pc_r + 32'd4;
                    end
                end else if (redirect) begin
                    tgt_n   = target_s;
                    state_n = S_KILL;
                end else begin
                    state_n = S_WAIT;
                end
            end
            S_KILL: begin
                if_valid_n = 1'b0;
                if (redirect) begin
                    tgt_n = target_s;
                end else begin
                    tgt_n = tgt_r;
                end
                if (ack_s) begin
                    pc_n    = redirect ? target_s : tgt_r;
                    state_n = S_RUN;
                end else begin
                    state_n = S_KILL;
                end
            end
            default: begin
                state_n    = S_RUN;
                if_valid_n = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_RUN;
            pc_r       <= PC_INIT;
            tgt_r      <= 32'd0;
            if_valid_r <= 1'b0;
            if_pc_r    <= 32'd0;
            if_instr_r <= 32'd0;
        end else begin
            state_r    <= state_n;
            pc_r       <= pc_n;
            tgt_r      <= tgt_n;
            if_valid_r <= if_valid_n;
            if_pc_r    <= if_pc_n;
            if_instr_r <= if_instr_n;
        end
    end

    assign imem.imem_req  = req_s;
    assign imem.imem_addr = pc_r;
    assign if_valid       = if_valid_r;
    assign if_pc          = if_pc_r;
    assign if_instr       = if_instr_r;
    assign if_npc         = if_pc_r + 32'd4;

endmodule
